// File: rtl/clk_div_pkg.sv
// Shared types and constants for the multi-channel clock/pulse divider.
package clk_div_pkg;

    // Counter and register width used by the configuration record.
    localparam int CFG_W = 32;

    // A divide ratio of zero halts the channel.
    localparam logic [CFG_W-1:0] DIV_HALT = '0;

    // One channel configuration: period, high-time and enable.
    typedef struct packed {
        logic [CFG_W-1:0] div;
        logic [CFG_W-1:0] high;
        logic             en;
    } div_cfg_t;

    // A channel produces output only when enabled with a non-zero period.
    function automatic logic cfg_running(input div_cfg_t c);
        return c.en && (c.div != DIV_HALT);
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: pending/active configuration, phase counter and
// registered outputs. New settings are adopted only at a period boundary,
// while idle, or on the global sync strobe, so the output never glitches.
module clk_div_chan
    import clk_div_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             we,
    input  logic [CFG_W-1:0] cfg_div,
    input  logic [CFG_W-1:0] cfg_high,
    input  logic             cfg_en,
    input  logic             sync_i,
    output logic             y,
    output logic             tick,
    output logic             pend
);

    div_cfg_t         act_q;
    div_cfg_t         pend_q;
    div_cfg_t         wr_cfg;
    div_cfg_t         act_d;
    logic [CFG_W-1:0] p_q;
    logic [CFG_W-1:0] p_d;
    logic             running;
    logic             boundary;
    logic             apply;
    logic             run_d;

    // Next-state decode: decide whether to adopt a new set and where the phase goes.
    // NOTE: every signal gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        wr_cfg   = '{div: cfg_div, high: cfg_high, en: cfg_en};
        running  = cfg_running(act_q);
        boundary = running && (p_q == act_q.div - CFG_W'(1));
        // An idle channel being written holds off one cycle so the write lands
        // in the pending set first; back-to-back writes then resolve last-wins.
        apply    = boundary || sync_i || (!running && !we);
        act_d    = act_q;
        if (apply) begin
            act_d = we ? wr_cfg : pend_q;
        end
        p_d = '0;
        if (!apply && running) begin
            p_d = p_q + CFG_W'(1);
        end
        run_d = cfg_running(act_d);
    end

    // State and output registers; outputs are computed from the next phase so
    // they line up with the counter value they describe.
    // NOTE: sequential state uses non-blocking assignments only, and every
    // register here (no memories) is cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            act_q  <= '0;
            pend_q <= '0;
            pend   <= 1'b0;
            p_q    <= '0;
            y      <= 1'b0;
            tick   <= 1'b0;
        end else begin
            act_q <= act_d;
            if (we) begin
                pend_q <= wr_cfg;
            end
            pend <= we ? !apply : (pend && !apply);
            p_q  <= p_d;
            y    <= run_d && (p_d < act_d.high);
            tick <= run_d && (p_d == '0);
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock/pulse divider: decodes the configuration
// write port and instantiates one independent divider per channel.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int CH  = 4,
    parameter int W   = CFG_W,
    parameter int CHW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           cfg_we,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [W-1:0]   cfg_div,
    input  logic [W-1:0]   cfg_high,
    input  logic           cfg_en,
    input  logic           sync_i,
    output logic [CH-1:0]  y_o,
    output logic [CH-1:0]  tick_o,
    output logic [CH-1:0]  pend_o
);

    // The configuration record in the package fixes the counter width.
    if (W != CFG_W) begin : g_bad_width
        $error("clk_div_multi: W must equal clk_div_pkg::CFG_W");
    end
    if (CH < 1 || CH > 16) begin : g_bad_ch
        $error("clk_div_multi: CH must be in 1..16");
    end

    // One channel per index; a write whose cfg_ch matches no index is dropped.
    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic we_ch;

        // Channel write strobe decode.
        always_comb begin
            we_ch = cfg_we && (cfg_ch == CHW'(i));
        end

        clk_div_chan u_chan (
            .clk      (clk),
            .rstn     (rstn),
            .we       (we_ch),
            .cfg_div  (cfg_div),
            .cfg_high (cfg_high),
            .cfg_en   (cfg_en),
            .sync_i   (sync_i),
            .y        (y_o[i]),
            .tick     (tick_o[i]),
            .pend     (pend_o[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi. Inputs change and outputs
// are sampled on the falling edge, away from the active rising edge.
module tb_clk_div_multi;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [31:0] cfg_div;
    logic [31:0] cfg_high;
    logic        cfg_en;
    logic        sync_i;
    logic [3:0]  y_o;
    logic [3:0]  tick_o;
    logic [3:0]  pend_o;

    // Second instance with a non-power-of-two channel count.
    logic        cfg_we2;
    logic [1:0]  cfg_ch2;
    logic [2:0]  y2;
    logic [2:0]  tick2;
    logic [2:0]  pend2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    clk_div_multi #(.CH(4), .W(32)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_high (cfg_high),
        .cfg_en   (cfg_en),
        .sync_i   (sync_i),
        .y_o      (y_o),
        .tick_o   (tick_o),
        .pend_o   (pend_o)
    );

    clk_div_multi #(.CH(3), .W(32)) dut3 (
        .clk      (clk),
        .rstn     (rstn),
        .cfg_we   (cfg_we2),
        .cfg_ch   (cfg_ch2),
        .cfg_div  (cfg_div),
        .cfg_high (cfg_high),
        .cfg_en   (cfg_en),
        .sync_i   (sync_i),
        .y_o      (y2),
        .tick_o   (tick2),
        .pend_o   (pend2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drive one write to the 4-channel instance across a single rising edge.
    task automatic write_cfg(input logic [1:0] ch, input logic [31:0] dv,
                             input logic [31:0] hi, input logic en);
        cfg_we   = 1'b1;
        cfg_ch   = ch;
        cfg_div  = dv;
        cfg_high = hi;
        cfg_en   = en;
        step();
        cfg_we   = 1'b0;
    endtask

    initial begin
        logic [3:0] ey;
        logic [3:0] et;

        rstn     = 1'b0;
        cfg_we   = 1'b0;
        cfg_ch   = '0;
        cfg_div  = '0;
        cfg_high = '0;
        cfg_en   = 1'b0;
        sync_i   = 1'b0;
        cfg_we2  = 1'b0;
        cfg_ch2  = '0;

        // Reset state.
        step();
        step();
        check("rst_y", 32'(y_o), 32'h0);
        check("rst_tick", 32'(tick_o), 32'h0);
        check("rst_pend", 32'(pend_o), 32'h0);
        rstn = 1'b1;
        step();
        check("idle_y", 32'(y_o), 32'h0);

        // ch0 div=4 high=2: pending after the write edge, running after the next.
        write_cfg(2'd0, 32'd4, 32'd2, 1'b1);
        check("t1_pend", 32'(pend_o), 32'h1);
        check("t1_tick_early", 32'(tick_o), 32'h0);
        check("t1_y_early", 32'(y_o), 32'h0);
        step();
        for (int k = 0; k < 8; k++) begin
            ey = 4'b0000;
            et = 4'b0000;
            ey[0] = (k % 4) < 2;
            et[0] = (k % 4) == 0;
            check($sformatf("t1_y_k%0d", k), 32'(y_o), 32'(ey));
            check($sformatf("t1_tick_k%0d", k), 32'(tick_o), 32'(et));
            check($sformatf("t1_pend_k%0d", k), 32'(pend_o), 32'h0);
            step();
        end

        // Reconfigure ch0 to div=6 high=1 while it sits at p=1.
        step();
        check("t2_y_p1", 32'(y_o), 32'h1);
        write_cfg(2'd0, 32'd6, 32'd1, 1'b1);
        check("t2_pend_p2", 32'(pend_o), 32'h1);
        check("t2_y_p2", 32'(y_o), 32'h0);
        check("t2_tick_p2", 32'(tick_o), 32'h0);
        step();
        check("t2_pend_p3", 32'(pend_o), 32'h1);
        check("t2_y_p3", 32'(y_o), 32'h0);
        step();
        for (int k = 0; k < 12; k++) begin
            ey = 4'b0000;
            ey[0] = (k % 6) == 0;
            check($sformatf("t2_y_k%0d", k), 32'(y_o), 32'(ey));
            check($sformatf("t2_tick_k%0d", k), 32'(tick_o), 32'(ey));
            check($sformatf("t2_pend_k%0d", k), 32'(pend_o), 32'h0);
            step();
        end

        // ch1 div=5 high=0 (always low), ch2 div=5 high=9 (always high).
        write_cfg(2'd1, 32'd5, 32'd0, 1'b1);
        write_cfg(2'd2, 32'd5, 32'd9, 1'b1);
        step();
        for (int k = 0; k < 10; k++) begin
            ey = 4'b0000;
            et = 4'b0000;
            ey[0] = ((k + 3) % 6) == 0;
            ey[2] = 1'b1;
            et[0] = ((k + 3) % 6) == 0;
            et[1] = ((k + 1) % 5) == 0;
            et[2] = (k % 5) == 0;
            check($sformatf("t3_y_k%0d", k), 32'(y_o), 32'(ey));
            check($sformatf("t3_tick_k%0d", k), 32'(tick_o), 32'(et));
            step();
        end

        // ch0 div=4 high=2 and ch1 div=6 high=3 pending at odd phases, then sync.
        write_cfg(2'd0, 32'd4, 32'd2, 1'b1);
        write_cfg(2'd1, 32'd6, 32'd3, 1'b1);
        check("t4_pend", 32'(pend_o), 32'h3);
        step();
        step();
        sync_i = 1'b1;
        step();
        sync_i = 1'b0;
        for (int k = 0; k < 13; k++) begin
            ey = 4'b0000;
            et = 4'b0000;
            ey[0] = (k % 4) < 2;
            ey[1] = (k % 6) < 3;
            ey[2] = 1'b1;
            et[0] = (k % 4) == 0;
            et[1] = (k % 6) == 0;
            et[2] = (k % 5) == 0;
            check($sformatf("t4_y_k%0d", k), 32'(y_o), 32'(ey));
            check($sformatf("t4_tick_k%0d", k), 32'(tick_o), 32'(et));
            check($sformatf("t4_pend_k%0d", k), 32'(pend_o), 32'h0);
            step();
        end

        // Disable ch2 mid-period (p=3): it keeps running to its boundary.
        write_cfg(2'd2, 32'd5, 32'd9, 1'b0);
        check("t5_pend_p4", 32'(pend_o[2]), 32'h1);
        check("t5_y_p4", 32'(y_o[2]), 32'h1);
        check("t5_tick_p4", 32'(tick_o[2]), 32'h0);
        step();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t5_y_off_k%0d", k), 32'(y_o[2]), 32'h0);
            check($sformatf("t5_tick_off_k%0d", k), 32'(tick_o[2]), 32'h0);
            check($sformatf("t5_pend_off_k%0d", k), 32'(pend_o[2]), 32'h0);
            step();
        end

        // ch3 div=1 high=1: constant high on both outputs.
        write_cfg(2'd3, 32'd1, 32'd1, 1'b1);
        check("t6_pend", 32'(pend_o[3]), 32'h1);
        check("t6_y_early", 32'(y_o[3]), 32'h0);
        step();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t6_y_k%0d", k), 32'(y_o[3]), 32'h1);
            check($sformatf("t6_tick_k%0d", k), 32'(tick_o[3]), 32'h1);
            step();
        end

        // Asynchronous reset mid-period clears outputs without a clock edge.
        rstn = 1'b0;
        #1;
        check("t7_y_async", 32'(y_o), 32'h0);
        check("t7_tick_async", 32'(tick_o), 32'h0);
        check("t7_pend_async", 32'(pend_o), 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("t7_y_idle_k%0d", k), 32'(y_o), 32'h0);
            check($sformatf("t7_tick_idle_k%0d", k), 32'(tick_o), 32'h0);
        end

        // Out-of-range channel on the 3-channel instance is ignored.
        cfg_we2  = 1'b1;
        cfg_ch2  = 2'd3;
        cfg_div  = 32'd2;
        cfg_high = 32'd1;
        cfg_en   = 1'b1;
        step();
        cfg_we2  = 1'b0;
        check("t8_pend_bad", 32'(pend2), 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("t8_y_bad_k%0d", k), 32'(y2), 32'h0);
            check($sformatf("t8_tick_bad_k%0d", k), 32'(tick2), 32'h0);
        end
        // A valid channel on the same instance does take the write.
        cfg_we2 = 1'b1;
        cfg_ch2 = 2'd2;
        step();
        cfg_we2 = 1'b0;
        check("t8_pend_ok", 32'(pend2), 32'h4);
        step();
        check("t8_tick_ok", 32'(tick2), 32'h4);
        check("t8_y_ok", 32'(y2), 32'h4);
        step();
        check("t8_tick_ok_p1", 32'(tick2), 32'h0);
        check("t8_y_ok_p1", 32'(y2), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
